// File: rtl/conv_loop_sequencer_pkg.sv
// Shared types and widths for the convolution loop sequencer and its address generator peer.
package conv_loop_sequencer_pkg;

  localparam int unsigned BYTE      = 8;
  localparam int unsigned HALF_WORD = 16;
  localparam int unsigned PAD_W     = 2 * BYTE + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [BYTE-1:0] i;
    logic [BYTE-1:0] j;
    logic [BYTE-1:0] k;
    logic [BYTE-1:0] m;
    logic [BYTE-1:0] n;
    logic [BYTE-1:0] l;
  } loop_idx_t;

endpackage

// File: rtl/conv_loop_sequencer_loop_counter.sv
// Single wrapping loop counter; o_wrap_c fires on the increment that returns it to zero,
// so it can drive the increment of the next-outer counter directly.
module conv_loop_sequencer_loop_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_bound,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap_c
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == (i_bound - WIDTH'(1)));
  assign o_wrap_c = i_inc & w_at_max;
  assign o_count  = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_at_max ? '0 : (r_count + WIDTH'(1));
    end
  end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Nested-loop tuple sequencer for the convolution layer: walks j,k,i,m,n,l one tuple per
// accepted beat, flags padding taps and accumulation boundaries, and honours back-pressure.
module conv_loop_sequencer
  import conv_loop_sequencer_pkg::*;
#(
  parameter int unsigned CONV_DIM_IMG    = 32,
  parameter int unsigned CONV_DIM_KERNEL = 5,
  parameter int unsigned CONV_DIM_CH     = 3,
  parameter int unsigned CONV_OUT_CH     = 32,
  parameter int unsigned CONV_DIM_OUT    = 32,
  parameter int unsigned STRIDE          = 1,
  parameter int unsigned PADDING         = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_stall,
  output logic [BYTE-1:0] o_i,
  output logic [BYTE-1:0] o_j,
  output logic [BYTE-1:0] o_k,
  output logic [BYTE-1:0] o_m,
  output logic [BYTE-1:0] o_n,
  output logic [BYTE-1:0] o_l,
  output logic            o_enable,
  output logic            o_pad,
  output logic            o_acc_first,
  output logic            o_acc_last,
  output logic            o_busy,
  output logic            o_done
);

  localparam logic [BYTE-1:0] B_OUT = BYTE'(CONV_DIM_OUT);
  localparam logic [BYTE-1:0] B_OCH = BYTE'(CONV_OUT_CH);
  localparam logic [BYTE-1:0] B_KER = BYTE'(CONV_DIM_KERNEL);
  localparam logic [BYTE-1:0] B_CH  = BYTE'(CONV_DIM_CH);
  localparam logic [BYTE-1:0] K_MAX = BYTE'(CONV_DIM_KERNEL - 1);
  localparam logic [BYTE-1:0] C_MAX = BYTE'(CONV_DIM_CH - 1);

  localparam logic signed [PAD_W-1:0] IMG_S = PAD_W'(CONV_DIM_IMG);
  localparam logic signed [PAD_W-1:0] PAD_S = PAD_W'(PADDING);
  localparam logic        [PAD_W-1:0] STR_U = PAD_W'(STRIDE);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  logic       r_enable;
  logic       r_busy;
  logic       r_done;
  logic       w_enable_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  logic       w_accept;
  logic       w_clear;
  loop_idx_t  w_idx;
  logic       w_wrap_l;
  logic       w_wrap_n;
  logic       w_wrap_m;
  logic       w_wrap_i;
  logic       w_wrap_k;
  logic       w_wrap_j;

  logic signed [PAD_W-1:0] w_row;
  logic signed [PAD_W-1:0] w_col;
  logic                    w_pad_tap;

  assign w_accept = (r_state == S_RUN) & ~i_stall;
  assign w_clear  = (r_state != S_RUN);

  // Innermost to outermost: l -> n -> m -> i -> k -> j, each carry driven by the inner wrap.
  conv_loop_sequencer_loop_counter #(.WIDTH(BYTE)) u_cnt_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bound  (B_CH),
    .i_inc    (w_accept),
    .i_clear  (w_clear),
    .o_count  (w_idx.l),
    .o_wrap_c (w_wrap_l)
  );

  conv_loop_sequencer_loop_counter #(.WIDTH(BYTE)) u_cnt_n (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bound  (B_KER),
    .i_inc    (w_wrap_l),
    .i_clear  (w_clear),
    .o_count  (w_idx.n),
    .o_wrap_c (w_wrap_n)
  );

  conv_loop_sequencer_loop_counter #(.WIDTH(BYTE)) u_cnt_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bound  (B_KER),
    .i_inc    (w_wrap_n),
    .i_clear  (w_clear),
    .o_count  (w_idx.m),
    .o_wrap_c (w_wrap_m)
  );

  conv_loop_sequencer_loop_counter #(.WIDTH(BYTE)) u_cnt_i (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bound  (B_OCH),
    .i_inc    (w_wrap_m),
    .i_clear  (w_clear),
    .o_count  (w_idx.i),
    .o_wrap_c (w_wrap_i)
  );

  conv_loop_sequencer_loop_counter #(.WIDTH(BYTE)) u_cnt_k (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bound  (B_OUT),
    .i_inc    (w_wrap_i),
    .i_clear  (w_clear),
    .o_count  (w_idx.k),
    .o_wrap_c (w_wrap_k)
  );

  conv_loop_sequencer_loop_counter #(.WIDTH(BYTE)) u_cnt_j (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bound  (B_OUT),
    .i_inc    (w_wrap_k),
    .i_clear  (w_clear),
    .o_count  (w_idx.j),
    .o_wrap_c (w_wrap_j)
  );

  // State and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_enable <= w_enable_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next state; the j wrap only fires when every inner counter is at its last value.
  always_comb begin
    w_state_nxt  = r_state;
    w_enable_nxt = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_wrap_j) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_enable_nxt = (w_state_nxt == S_RUN);
    w_busy_nxt   = (w_state_nxt == S_RUN);
    w_done_nxt   = (w_state_nxt == S_DONE);
  end

  // Tap position in the unpadded image, signed so the top/left border goes negative.
  assign w_row = $signed(STR_U * PAD_W'(w_idx.j)) + $signed(PAD_W'(w_idx.m)) - PAD_S;
  assign w_col = $signed(STR_U * PAD_W'(w_idx.k)) + $signed(PAD_W'(w_idx.n)) - PAD_S;

  assign w_pad_tap = w_row[PAD_W-1] | (w_row >= IMG_S) |
                     w_col[PAD_W-1] | (w_col >= IMG_S);

  assign o_i         = w_idx.i;
  assign o_j         = w_idx.j;
  assign o_k         = w_idx.k;
  assign o_m         = w_idx.m;
  assign o_n         = w_idx.n;
  assign o_l         = w_idx.l;
  assign o_enable    = r_enable;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pad       = r_enable & w_pad_tap;
  assign o_acc_first = r_enable & (w_idx.m == '0) & (w_idx.n == '0) & (w_idx.l == '0);
  assign o_acc_last  = r_enable & (w_idx.m == K_MAX) & (w_idx.n == K_MAX) & (w_idx.l == C_MAX);

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed bench for conv_loop_sequencer on the small 4x4 / K=3 / CH=2 / OCH=2 configuration.
module tb_conv_loop_sequencer;
  import conv_loop_sequencer_pkg::*;

  localparam int IMG   = 4;
  localparam int K     = 3;
  localparam int CH    = 2;
  localparam int OCH   = 2;
  localparam int OUT   = 4;
  localparam int STR   = 1;
  localparam int PD    = 1;
  localparam int BEATS = OUT * OUT * OCH * K * K * CH;

  logic            clk;
  logic            rst_n;
  logic            i_start;
  logic            i_stall;
  logic [BYTE-1:0] o_i, o_j, o_k, o_m, o_n, o_l;
  logic            o_enable, o_pad, o_acc_first, o_acc_last, o_busy, o_done;

  conv_loop_sequencer #(
    .CONV_DIM_IMG    (IMG),
    .CONV_DIM_KERNEL (K),
    .CONV_DIM_CH     (CH),
    .CONV_OUT_CH     (OCH),
    .CONV_DIM_OUT    (OUT),
    .STRIDE          (STR),
    .PADDING         (PD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_stall     (i_stall),
    .o_i         (o_i),
    .o_j         (o_j),
    .o_k         (o_k),
    .o_m         (o_m),
    .o_n         (o_n),
    .o_l         (o_l),
    .o_enable    (o_enable),
    .o_pad       (o_pad),
    .o_acc_first (o_acc_first),
    .o_acc_last  (o_acc_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] i, j, k, m, n, l;
    logic       pad, af, al;
  } tup_t;

  typedef struct {
    int   beat;
    tup_t exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  tup_t cap [BEATS];
  vec_t vecs [10];

  function automatic tup_t mk(input int i, j, k, m, n, l, input bit pad, af, al);
    tup_t t;
    t.i = 8'(i); t.j = 8'(j); t.k = 8'(k); t.m = 8'(m); t.n = 8'(n); t.l = 8'(l);
    t.pad = pad; t.af = af; t.al = al;
    return t;
  endfunction

  // Reference: decompose the beat number into the loop indices.
  function automatic tup_t model(input int b);
    int   r, c;
    tup_t t;
    t.l = 8'(b % CH);
    t.n = 8'((b / CH) % K);
    t.m = 8'((b / (CH * K)) % K);
    t.i = 8'((b / (CH * K * K)) % OCH);
    t.k = 8'((b / (CH * K * K * OCH)) % OUT);
    t.j = 8'(b / (CH * K * K * OCH * OUT));
    r = STR * int'(t.j) + int'(t.m) - PD;
    c = STR * int'(t.k) + int'(t.n) - PD;
    t.pad = (r < 0) || (r >= IMG) || (c < 0) || (c >= IMG);
    t.af  = (t.m == 0) && (t.n == 0) && (t.l == 0);
    t.al  = (int'(t.m) == K - 1) && (int'(t.n) == K - 1) && (int'(t.l) == CH - 1);
    return t;
  endfunction

  function automatic tup_t grab();
    return {o_i, o_j, o_k, o_m, o_n, o_l, o_pad, o_acc_first, o_acc_last};
  endfunction

  task automatic check_tup(input string nm, input tup_t act, input tup_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got i%0d j%0d k%0d m%0d n%0d l%0d pad%0b af%0b al%0b, want i%0d j%0d k%0d m%0d n%0d l%0d pad%0b af%0b al%0b",
               nm, act.i, act.j, act.k, act.m, act.n, act.l, act.pad, act.af, act.al,
               exp.i, exp.j, exp.k, exp.m, exp.n, exp.l, exp.pad, exp.af, exp.al);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_ctrl(input string nm, input logic en, input logic bsy, input logic dn);
    check_int({nm, "_enable"}, int'(o_enable), int'(en));
    check_int({nm, "_busy"}, int'(o_busy), int'(bsy));
    check_int({nm, "_done"}, int'(o_done), int'(dn));
  endtask

  // One layer pass; stall/abort/start-poke are keyed on the accepted-beat count (-1 = off).
  task automatic run_pass(input int stall_at, input int stall_len, input int abort_at,
                          input int poke_at, input bit capture);
    int   b = 0;
    int   cyc = 0;
    int   stall_left = 0;
    bit   stalled = 0;
    bit   fin = 0;
    int   pads = 0, exp_pads = 0, afs = 0, als = 0, af_beat = -1;
    tup_t t;
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    while (!fin && cyc < 2000) begin
      cyc++;
      i_start = 1'b0;
      if (o_enable) begin
        t = grab();
        check_tup("tuple", t, model(b));
        if (capture) cap[b] = t;
        if (b == abort_at) begin
          rst_n   = 1'b0;
          i_stall = 1'b0;
          #1;
          check_tup("abort_tuple", grab(), '0);
          check_ctrl("abort", 1'b0, 1'b0, 1'b0);
          i_start = 1'b1;
          repeat (2) begin
            @(negedge clk);
            check_ctrl("abort_hold", 1'b0, 1'b0, 1'b0);
          end
          rst_n   = 1'b1;
          i_start = 1'b0;
          repeat (2) begin
            @(negedge clk);
            check_ctrl("abort_idle", 1'b0, 1'b0, 1'b0);
          end
          return;
        end
        if (b == stall_at && !stalled) begin
          stalled    = 1'b1;
          stall_left = stall_len;
        end
        if (stall_left > 0) begin
          i_stall = 1'b1;
          stall_left--;
        end else begin
          i_stall = 1'b0;
          pads += int'(t.pad);
          if (t.af) begin
            afs++;
            af_beat = b;
          end
          if (t.al) begin
            als++;
            check_int("af_to_al_gap", b - af_beat, 17);
          end
          b++;
        end
        if (b == poke_at) i_start = 1'b1;
      end else begin
        i_stall = 1'b0;
        check_int("done_pulse", int'(o_done), 1);
        check_int("done_busy", int'(o_busy), 0);
        check_int("beats_at_done", b, BEATS);
        fin = 1'b1;
      end
      @(negedge clk);
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL pass_timeout: got %0d beats after %0d cycles, want %0d", b, cyc, BEATS);
    end
    check_ctrl("post_done", 1'b0, 1'b0, 1'b0);
    for (int x = 0; x < BEATS; x++) exp_pads += int'(model(x).pad);
    check_int("pad_count", pads, exp_pads);
    check_int("acc_first_count", afs, 32);
    check_int("acc_last_count", als, 32);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_tup("reset_tuple", grab(), '0);
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_ctrl("idle", 1'b0, 1'b0, 1'b0);

    vecs[0] = '{0,   mk(0, 0, 0, 0, 0, 0, 1, 1, 0)};
    vecs[1] = '{1,   mk(0, 0, 0, 0, 0, 1, 1, 0, 0)};
    vecs[2] = '{2,   mk(0, 0, 0, 0, 1, 0, 1, 0, 0)};
    vecs[3] = '{17,  mk(0, 0, 0, 2, 2, 1, 0, 0, 1)};
    vecs[4] = '{18,  mk(1, 0, 0, 0, 0, 0, 1, 1, 0)};
    vecs[5] = '{36,  mk(0, 0, 1, 0, 0, 0, 1, 1, 0)};
    vecs[6] = '{50,  mk(0, 0, 1, 2, 1, 0, 0, 0, 0)};
    vecs[7] = '{188, mk(0, 1, 1, 1, 1, 0, 0, 0, 0)};
    vecs[8] = '{444, mk(0, 3, 0, 2, 0, 0, 1, 0, 0)};
    vecs[9] = '{575, mk(1, 3, 3, 2, 2, 1, 1, 0, 1)};

    run_pass(-1, 0, -1, -1, 1'b1);
    for (int v = 0; v < 10; v++) begin
      check_tup($sformatf("vec_beat%0d", vecs[v].beat), cap[vecs[v].beat], vecs[v].exp);
    end

    run_pass(200, 5, -1, -1, 1'b0);
    run_pass(-1, 0, 100, -1, 1'b0);
    run_pass(-1, 0, -1, 300, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
